icache_axi_responder: RTL and testbench
=======================================

# icache_axi_responder

AXI4 read-only responder that answers ICache refill bursts from an internal word-addressed backing memory, with a fixed configurable access latency. It is the slave end of the ICache AXI read channel and stands in for the L2 or memory side in frontend-only simulation and FPGA bring-up. It serves one outstanding burst at a time and supports INCR, WRAP and FIXED bursts. A side write port preloads the memory with program images.

## Interface
Parameters:
- DATA_WIDTH, 32: R data width in bits; one memory word per beat (bytes B = DATA_WIDTH/8).
- ADDR_WIDTH, 32: AR address width.
- ID_WIDTH, 4: AR/R id width.
- MEM_DEPTH, 1024: memory words; must be a power of two.
- LATENCY, 4: cycles from AR handshake to first R beat, minus one; 0 is legal.

Ports:
- clk in 1: single clock; all logic rises on posedge.
- rst in 1: reset, asynchronous, active-low.
- arvalid in 1: read address valid.
- arready out 1: read address ready.
- araddr in ADDR_WIDTH: byte address of the first beat.
- arid in ID_WIDTH: transaction id.
- arlen in 8: beats minus one.
- arsize in 3: log2 of bytes per beat.
- arburst in 2: burst type; 00 FIXED, 01 INCR, 10 WRAP.
- rvalid out 1: read data valid.
- rready in 1: read data ready.
- rdata out DATA_WIDTH: beat data.
- rid out ID_WIDTH: echoes the captured arid.
- rresp out 2: 00 OKAY, 10 SLVERR, 11 DECERR.
- rlast out 1: marks the final beat.
- pwe in 1: preload write enable.
- pwaddr in log2(MEM_DEPTH): preload word index.
- pwdata in DATA_WIDTH: preload data.

## Operation
- FSM states IDLE, WAIT, BURST. Reset state is IDLE.
- IDLE: arready=1.
  - On arvalid&&arready, capture addr, id, len, size and burst, and mark the transaction in error if any of these hold: arsize≠log2(B), arburst=11, or WRAP with arlen∉{1,3,7,15}.
  - If LATENCY>0, go to WAIT and load the latency counter with LATENCY-1; otherwise go to BURST.
- WAIT: arready=0. Decrement the counter each cycle. At 0, go to BURST.
- BURST: rvalid=1.
  - rid = captured id.
  - rdata = mem[word index], where the word index is addr[log2(B) +: log2(MEM_DEPTH)].
  - rlast = (beat counter == len).
- On rvalid&&rready:
  - Advance the beat.
  - If rlast, return to IDLE; arready rises the next cycle. There is no back-to-back AR acceptance in the same cycle as rlast.
- Address advance:
  - INCR: addr += B.
  - FIXED: addr unchanged.
  - WRAP: wrap size W = (len+1)*B, aligned to a power of two by construction. addr = (addr & ~(W-1)) | ((addr+B) & (W-1)), giving critical-word-first then wrap.
- Response codes:
  - Error transaction: rresp=10 on all len+1 beats, rdata=0.
  - Address out of range (any captured-address bit above the memory index is nonzero, checked per beat): rresp=11, rdata=0 for that beat only.
  - Otherwise rresp=00.
- The beat counter is 8 bits. arlen=255 yields 256 beats.
- Preload:
  - pwe writes pwdata to mem[pwaddr] at posedge, in any state.
  - A preload to the word currently presented leaves the held rdata unchanged. Data is latched into the R output register when a beat is first presented.
- rdata, rresp and rlast are registered outputs. They hold stable while rvalid&&!rready.
- Memory contents are not reset.

## Timing
- Output reset values:
  - arready: 1.
  - rvalid, rlast: 0.
  - rdata, rid, rresp: 0.
- AR handshake on posedge T puts the first rvalid high in the cycle after posedge T+1+LATENCY.
  - Example, LATENCY=4: handshake at edge 10, first beat visible after edge 15.
- With rready held high, beats complete one per cycle, so a burst of len+1 beats occupies len+1 cycles of rvalid.
- rready low stalls: no state change, outputs held.
- Asynchronous reset mid-burst drops the transaction immediately:
  - rvalid=0 and arready=1 as soon as reset is asserted.
  - The first acceptance is possible at the first posedge after deassertion.

## Test plan
- Preload mem[0..7]=0x100+i, LATENCY=4, then AR INCR addr=0x0 len=3 id=5 with rready=1 -> first beat 5 cycles after the handshake; beats 0x100..0x103; rid=5; rresp=00; rlast on the 4th beat only.
- WRAP addr=0x18 len=7 -> data sequence 0x106,0x107,0x100,0x101,…,0x105; arready=0 throughout the burst.
- Random rready toggling (50%) on an INCR len=15 burst -> rdata, rresp and rlast stable whenever rvalid&&!rready; 16 beats with no loss or duplication.
- Error cases:
  - arsize=1 with DATA_WIDTH=32, len=1 -> two beats, rresp=10, rdata=0.
  - INCR from the last in-range word, len=1 -> beat0 rresp=00, beat1 rresp=11.
- LATENCY=0 and arlen=255 -> rvalid in the cycle after the handshake; 256 beats; rlast on beat 255; arready=1 the cycle after.
- Assert rst low mid-burst at beat 2 -> rvalid drops to 0 and arready rises immediately; the next AR after release is served from beat 0 with the new id.

Source files
------------

// File: rtl/icache_axi_responder.sv
// rtl/icache_axi_responder.sv - AXI4 read responder serving ICache refill bursts from a preloadable word memory
module icache_axi_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         arvalid_i,
    output logic                         arready_o,
    input  logic [ADDR_WIDTH-1:0]        araddr_i,
    input  logic [ID_WIDTH-1:0]          arid_i,
    input  logic [7:0]                   arlen_i,
    input  logic [2:0]                   arsize_i,
    input  logic [1:0]                   arburst_i,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic [ID_WIDTH-1:0]          rid_o,
    output logic [1:0]                   rresp_o,
    output logic                         rlast_o,
    input  logic                         pwe_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] pwaddr_i,
    input  logic [DATA_WIDTH-1:0]        pwdata_i
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_DEPTH);
    localparam int CW    = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
    localparam logic [2:0]            SIZE_OK = 3'(OFF);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            len_q, len_d;
    logic [1:0]            burst_q, burst_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            beat_q, beat_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;

    logic [ADDR_WIDTH-1:0] wrap_mask, addr_nxt, ld_addr;
    logic [7:0]            ld_beat;
    logic                  ld_oor;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [1:0]            ld_resp;

    // Address of the following beat and the beat to load into the R register
    always_comb begin
        wrap_mask = (({{(ADDR_WIDTH-8){1'b0}}, len_q} + ONE_A) << OFF) - ONE_A;
        case (burst_q)
            2'b00:   addr_nxt = addr_q;
            2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + STEP) & wrap_mask);
            default: addr_nxt = addr_q + STEP;
        endcase
        // First presentation uses the captured address; later ones advance past the accepted beat
        ld_addr = rvalid_q ? addr_nxt : addr_q;
        ld_beat = rvalid_q ? (beat_q + 8'd1) : beat_q;
        ld_oor  = (ld_addr >> (OFF + IDXW)) != '0;
        if (err_q) begin
            ld_data = '0;
            ld_resp = 2'b10;
        end else if (ld_oor) begin
            ld_data = '0;
            ld_resp = 2'b11;
        end else begin
            ld_data = mem[ld_addr[OFF +: IDXW]];
            ld_resp = 2'b00;
        end
    end

    // FSM next state, AR capture and R output register loading
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        burst_d   = burst_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        arready_o = 1'b0;
        case (state_q)
            IDLE: begin
                arready_o = 1'b1;
                if (arvalid_i) begin
                    addr_d  = araddr_i;
                    id_d    = arid_i;
                    len_d   = arlen_i;
                    burst_d = arburst_i;
                    beat_d  = '0;
                    err_d   = (arsize_i != SIZE_OK) || (arburst_i == 2'b11) ||
                              ((arburst_i == 2'b10) && !(arlen_i inside {8'd1, 8'd3, 8'd7, 8'd15}));
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = BURST;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            BURST: begin
                if (!rvalid_q || rready_i) begin
                    if (rvalid_q && rlast_q) begin
                        state_d  = IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end else begin
                        rvalid_d = 1'b1;
                        addr_d   = ld_addr;
                        beat_d   = ld_beat;
                        rdata_d  = ld_data;
                        rresp_d  = ld_resp;
                        rlast_d  = (ld_beat == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            beat_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            len_q    <= len_d;
            burst_q  <= burst_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
    end

    // Preload port; memory contents survive reset
    always_ff @(posedge clk_i) begin
        if (pwe_i) begin
            mem[pwaddr_i] <= pwdata_i;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign rid_o    = id_q;
    assign rresp_o  = rresp_q;
    assign rlast_o  = rlast_q;
endmodule

// File: tb/tb_icache_axi_responder.sv
// tb/tb_icache_axi_responder.sv - scoreboard bench driving a LATENCY=4 and a LATENCY=0 responder in lockstep
module tb_icache_axi_responder;
    localparam int LAT0 = 4;
    localparam int LAT1 = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
        bit          first;
        int          hs;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arvalid = 1'b0;
    logic [31:0] araddr = '0;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        rready = 1'b1;
    logic        pwe = 1'b0;
    logic [9:0]  pwaddr = '0;
    logic [31:0] pwdata = '0;

    logic        arready_w [2];
    logic        rvalid_w  [2];
    logic [31:0] rdata_w   [2];
    logic [3:0]  rid_w     [2];
    logic [1:0]  rresp_w   [2];
    logic        rlast_w   [2];

    beat_t       sb [2][$];
    logic [31:0] mem_m [1024];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          rr_rand = 1'b0;
    bit          seen [2];
    bit          chk_idle [2];

    icache_axi_responder #(.LATENCY(LAT0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .arvalid_i(arvalid), .arready_o(arready_w[0]), .araddr_i(araddr), .arid_i(arid),
        .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
        .rvalid_o(rvalid_w[0]), .rready_i(rready), .rdata_o(rdata_w[0]), .rid_o(rid_w[0]),
        .rresp_o(rresp_w[0]), .rlast_o(rlast_w[0]),
        .pwe_i(pwe), .pwaddr_i(pwaddr), .pwdata_i(pwdata)
    );

    icache_axi_responder #(.LATENCY(LAT1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .arvalid_i(arvalid), .arready_o(arready_w[1]), .araddr_i(araddr), .arid_i(arid),
        .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
        .rvalid_o(rvalid_w[1]), .rready_i(rready), .rdata_o(rdata_w[1]), .rid_o(rid_w[1]),
        .rresp_o(rresp_w[1]), .rlast_o(rlast_w[1]),
        .pwe_i(pwe), .pwaddr_i(pwaddr), .pwdata_i(pwdata)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        rready = rr_rand ? 1'($urandom % 2) : 1'b1;
    end

    function automatic string nm(input string s, input int d);
        return $sformatf("%s_dut%0d", s, d);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected beats straight from the burst rules: byte address of beat i, then range and error tests
    task automatic push_burst(input logic [31:0] addr, input logic [3:0] id, input int len,
                              input logic [2:0] size, input logic [1:0] burst, input int hs);
        bit          err;
        int unsigned w, base, a;
        beat_t       b;
        err = (size != 3'd2) || (burst == 2'b11) ||
              ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
        w = (len + 1) * 4;
        for (int i = 0; i <= len; i++) begin
            case (burst)
                2'b00:   a = addr;
                2'b10: begin
                    base = addr - (addr % w);
                    a = base + ((addr - base) + i * 4) % w;
                end
                default: a = addr + i * 4;
            endcase
            if (err) begin
                b.data = '0;
                b.resp = 2'b10;
            end else if (a >= 32'd4096) begin
                b.data = '0;
                b.resp = 2'b11;
            end else begin
                b.data = mem_m[a / 4];
                b.resp = 2'b00;
            end
            b.last  = (i == len);
            b.first = (i == 0);
            b.id    = id;
            b.hs    = hs;
            sb[0].push_back(b);
            sb[1].push_back(b);
        end
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input bit wait_edge);
        if (wait_edge) begin
            @(posedge clk);
            #1;
        end
        chk("ar_ready_dut0", 32'(arready_w[0]), 32'd1);
        chk("ar_ready_dut1", 32'(arready_w[1]), 32'd1);
        arvalid = 1'b1;
        araddr  = addr;
        arid    = id;
        arlen   = 8'(len);
        arsize  = size;
        arburst = burst;
        push_burst(addr, id, len, size, burst, cyc + 1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && (sb[0].size() != 0 || sb[1].size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        chk("burst_done", 32'(sb[0].size() + sb[1].size()), 32'd0);
        sb[0].delete();
        sb[1].delete();
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        @(posedge clk);
        #1;
        pwe    = 1'b1;
        pwaddr = 10'(idx);
        pwdata = v;
        mem_m[idx] = v;
        @(posedge clk);
        #1;
        pwe = 1'b0;
    endtask

    // Monitor: every presented beat is compared with the scoreboard head, stalled beats included
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (chk_idle[d]) begin
                    chk_idle[d] = 1'b0;
                    chk(nm("after_last_arready", d), 32'(arready_w[d]), 32'd1);
                    chk(nm("after_last_rvalid", d), 32'(rvalid_w[d]), 32'd0);
                end
                if (rvalid_w[d]) begin
                    if (sb[d].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL %s actual=beat expected=none", nm("unexpected_beat", d));
                    end else begin
                        e = sb[d][0];
                        if (e.first && !seen[d])
                            chk(nm("first_beat_cycle", d), 32'(cyc), 32'(e.hs + 1 + ((d == 0) ? LAT0 : LAT1)));
                        seen[d] = 1'b1;
                        chk(nm("rdata", d), rdata_w[d], e.data);
                        chk(nm("rresp", d), 32'(rresp_w[d]), 32'(e.resp));
                        chk(nm("rlast", d), 32'(rlast_w[d]), 32'(e.last));
                        chk(nm("rid", d), 32'(rid_w[d]), 32'(e.id));
                        chk(nm("arready_busy", d), 32'(arready_w[d]), 32'd0);
                        if (rready) begin
                            void'(sb[d].pop_front());
                            seen[d] = 1'b0;
                            if (e.last) chk_idle[d] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] v;
        int          len;
        int          lens [6] = '{0, 1, 3, 7, 15, 2};

        #3;
        for (int d = 0; d < 2; d++) begin
            chk(nm("rst_arready", d), 32'(arready_w[d]), 32'd1);
            chk(nm("rst_rvalid", d), 32'(rvalid_w[d]), 32'd0);
            chk(nm("rst_rlast", d), 32'(rlast_w[d]), 32'd0);
            chk(nm("rst_rdata", d), rdata_w[d], 32'd0);
            chk(nm("rst_rid", d), 32'(rid_w[d]), 32'd0);
            chk(nm("rst_rresp", d), 32'(rresp_w[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 1024; i++) begin
            @(posedge clk);
            #1;
            v = (i < 8) ? 32'h100 + 32'(i) : $urandom;
            pwe = 1'b1;
            pwaddr = 10'(i);
            pwdata = v;
            mem_m[i] = v;
        end
        @(posedge clk);
        #1;
        pwe = 1'b0;

        send_ar(32'h0, 4'd5, 3, 3'd2, 2'b01, 1'b1);
        wait_done();
        send_ar(32'h18, 4'd6, 7, 3'd2, 2'b10, 1'b1);
        wait_done();
        rr_rand = 1'b1;
        send_ar(32'h40, 4'd7, 15, 3'd2, 2'b01, 1'b1);
        wait_done();
        rr_rand = 1'b0;
        send_ar(32'h20, 4'd8, 1, 3'd1, 2'b01, 1'b1);
        wait_done();
        send_ar(32'hFFC, 4'd9, 1, 3'd2, 2'b01, 1'b1);
        wait_done();
        send_ar(32'h10, 4'd10, 3, 3'd2, 2'b00, 1'b1);
        wait_done();
        send_ar(32'h0, 4'd11, 255, 3'd2, 2'b01, 1'b1);
        wait_done();

        for (int t = 0; t < 30; t++) begin
            if ($urandom % 2 == 1) preload(int'($urandom % 1024), $urandom);
            rr_rand = 1'($urandom % 2);
            len = ($urandom % 3 == 0) ? int'($urandom_range(0, 40)) : lens[$urandom % 6];
            send_ar(32'($urandom_range(0, 1100)) * 32'd4, 4'($urandom), len,
                    ($urandom % 6 == 0) ? 3'($urandom) : 3'd2, 2'($urandom), 1'b1);
            wait_done();
        end
        rr_rand = 1'b0;

        send_ar(32'h0, 4'd12, 7, 3'd2, 2'b01, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid_w[0]) break;
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(nm("midrst_rvalid", d), 32'(rvalid_w[d]), 32'd0);
            chk(nm("midrst_arready", d), 32'(arready_w[d]), 32'd1);
            chk(nm("midrst_rid", d), 32'(rid_w[d]), 32'd0);
            sb[d].delete();
            seen[d] = 1'b0;
            chk_idle[d] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        send_ar(32'h8, 4'd13, 3, 3'd2, 2'b01, 1'b0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
